// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage -- pipeline execute stage
//
// Purpose:
//   Sits between the ID/EX and EX/MEM pipeline registers. It does three jobs:
//   - picks each operand from the EX/MEM or MEM/WB forwarding paths, or from
//     the ID/EX operand value;
//   - computes single-cycle ALU results combinationally;
//   - runs a WIDTH-iteration shift-add multiplier and a restoring unsigned
//     divider under a small FSM. stall_o is held high towards the hazard unit
//     for the whole multi-cycle operation.
//
// Optional feature (macro EX_HILO_EN):
//   When defined, a HI register captures the high product half (MUL) or the
//   remainder (DIVU), and aluop 4'hE (MFHI) reads it back. When undefined,
//   those bits are dropped and aluop 4'hE returns zero.
//
// Ports:
//   CLK, RST               clock (posedge), asynchronous active-high reset
//   aluop_i                operation code from ID/EX
//   alusrc1_i, alusrc2_i   operand values from ID/EX
//   regsrc1_i, regsrc2_i   source register indices (NOREG = no register)
//   regwrite_i, regdst_i   writeback enable / destination from ID/EX
//   exmem_*                EX/MEM forwarding source (regwrite, regdst, result)
//   memwb_*                MEM/WB forwarding source (regwrite, regdst, result)
//   result_o, zero_o       ALU result to EX/MEM and its zero flag
//   regwrite_o             regwrite_i, forced low while stalled
//   regdst_o               regdst_i passthrough
//   stall_o                freeze IF/ID and ID/EX, bubble EX/MEM
// ============================================================================
module ex_stage #(
   parameter int         WIDTH = 16,
   parameter logic [3:0] NOREG = 4'hF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [3:0]       aluop_i,
   input  logic [WIDTH-1:0] alusrc1_i,
   input  logic [WIDTH-1:0] alusrc2_i,
   input  logic [3:0]       regsrc1_i,
   input  logic [3:0]       regsrc2_i,
   input  logic             regwrite_i,
   input  logic [3:0]       regdst_i,
   input  logic             exmem_regwrite_i,
   input  logic [3:0]       exmem_regdst_i,
   input  logic [WIDTH-1:0] exmem_result_i,
   input  logic             memwb_regwrite_i,
   input  logic [3:0]       memwb_regdst_i,
   input  logic [WIDTH-1:0] memwb_result_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             regwrite_o,
   output logic [3:0]       regdst_o,
   output logic             stall_o
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SLL  = 4'h6;
   localparam logic [3:0] OP_SRL  = 4'h7;
   localparam logic [3:0] OP_SRA  = 4'h8;
   localparam logic [3:0] OP_SLT  = 4'h9;
   localparam logic [3:0] OP_SLTU = 4'hA;
   localparam logic [3:0] OP_PASB = 4'hB;
   localparam logic [3:0] OP_MUL  = 4'hC;
   localparam logic [3:0] OP_DIVU = 4'hD;
   localparam logic [3:0] OP_MFHI = 4'hE;
   localparam logic [3:0] OP_PASA = 4'hF;

   logic [1:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_r;          // latched multiplicand
   logic [WIDTH-1:0] b_r;          // latched divisor
   logic             div_r;        // 1: divide in progress, 0: multiply
   logic [WIDTH-1:0] hi_r;         // product high half / partial remainder
   logic [WIDTH-1:0] lo_r;         // multiplier->product low / dividend->quotient

   logic [WIDTH-1:0] op_a_s;
   logic [WIDTH-1:0] op_b_s;
   logic             is_muldiv_s;
   logic [WIDTH-1:0] hi_nxt_s;
   logic [WIDTH-1:0] lo_nxt_s;
   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] alu_s;
   logic [WIDTH-1:0] hi_val_s;
   logic [WIDTH-1:0] result_s;
   logic             stall_s;
   logic [CNT_W-1:0] sh_s;

   assign is_muldiv_s = (aluop_i == OP_MUL) || (aluop_i == OP_DIVU);
   assign sh_s        = op_b_s[CNT_W-1:0];

   // Operand A source select; EX/MEM is newer than MEM/WB so it wins
   always_comb begin
      if ((regsrc1_i != NOREG) && exmem_regwrite_i && (exmem_regdst_i == regsrc1_i)) begin
         op_a_s = exmem_result_i;
      end else if ((regsrc1_i != NOREG) && memwb_regwrite_i && (memwb_regdst_i == regsrc1_i)) begin
         op_a_s = memwb_result_i;
      end else begin
         op_a_s = alusrc1_i;
      end
   end

   // Operand B source select; same priority as operand A
   always_comb begin
      if ((regsrc2_i != NOREG) && exmem_regwrite_i && (exmem_regdst_i == regsrc2_i)) begin
         op_b_s = exmem_result_i;
      end else if ((regsrc2_i != NOREG) && memwb_regwrite_i && (memwb_regdst_i == regsrc2_i)) begin
         op_b_s = memwb_result_i;
      end else begin
         op_b_s = alusrc2_i;
      end
   end

   // One mul/div iteration. Both share the {hi_r, lo_r} pair:
   // the multiply adds into hi and shifts the whole pair right;
   // the divide shifts the pair left and keeps the trial subtract when it
   // is non-negative. A zero divisor therefore yields all-ones quotient
   // and the dividend as remainder without special casing.
   always_comb begin
      add_s   = {1'b0, hi_r} + {1'b0, a_r};
      trial_s = {hi_r, lo_r[WIDTH-1]} - {1'b0, b_r};
      if (div_r) begin
         if (!trial_s[WIDTH]) begin
            hi_nxt_s = trial_s[WIDTH-1:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
            lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (lo_r[0]) begin
            {hi_nxt_s, lo_nxt_s} = {add_s, lo_r[WIDTH-1:1]};
         end else begin
            {hi_nxt_s, lo_nxt_s} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
         end
      end
   end

   // FSM and mul/div datapath registers; operands are captured at issue so
   // the forwarding sources may drain freely during the stall
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         div_r   <= 1'b0;
         hi_r    <= {WIDTH{1'b0}};
         lo_r    <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (is_muldiv_s) begin
                  state_r <= ST_RUN;
                  cnt_r   <= {CNT_W{1'b0}};
                  a_r     <= op_a_s;
                  b_r     <= op_b_s;
                  div_r   <= (aluop_i == OP_DIVU);
                  hi_r    <= {WIDTH{1'b0}};
                  lo_r    <= (aluop_i == OP_DIVU) ? op_a_s : op_b_s;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               hi_r  <= hi_nxt_s;
               lo_r  <= lo_nxt_s;
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_r == CNT_W'(WIDTH - 1)) begin
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               // never re-arm on the same instruction: ID/EX advances now
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef EX_HILO_EN
   logic [WIDTH-1:0] hilo_r;

   // HI register: captures high product half or remainder when the op retires
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hilo_r <= {WIDTH{1'b0}};
      end else if (state_r == ST_DONE) begin
         hilo_r <= hi_r;
      end else begin
         hilo_r <= hilo_r;
      end
   end

   assign hi_val_s = hilo_r;
`else
   assign hi_val_s = {WIDTH{1'b0}};
`endif

   // Single-cycle ALU on the forwarded operands
   always_comb begin
      alu_s = {WIDTH{1'b0}};
      case (aluop_i)
         OP_ADD:  alu_s = op_a_s + op_b_s;
         OP_SUB:  alu_s = op_a_s - op_b_s;
         OP_AND:  alu_s = op_a_s & op_b_s;
         OP_OR:   alu_s = op_a_s | op_b_s;
         OP_XOR:  alu_s = op_a_s ^ op_b_s;
         OP_NOT:  alu_s = ~op_a_s;
         OP_SLL:  alu_s = op_a_s << sh_s;
         OP_SRL:  alu_s = op_a_s >> sh_s;
         OP_SRA:  alu_s = $signed(op_a_s) >>> sh_s;
         OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
         OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
         OP_PASB: alu_s = op_b_s;
         OP_MFHI: alu_s = hi_val_s;
         OP_PASA: alu_s = op_a_s;
         default: alu_s = {WIDTH{1'b0}};    // MUL/DIVU go through the FSM
      endcase
   end

   // Stall request; reset must release the hazard unit immediately
   always_comb begin
      if (RST) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: stall_s = is_muldiv_s;
            ST_RUN:  stall_s = 1'b1;
            default: stall_s = 1'b0;
         endcase
      end
   end

   // Result select: latched mul/div result on retire, ALU otherwise
   always_comb begin
      case (state_r)
         ST_DONE: result_s = lo_r;
         ST_RUN:  result_s = {WIDTH{1'b0}};
         default: result_s = alu_s;
      endcase
   end

   assign result_o   = result_s;
   assign zero_o     = (result_s == {WIDTH{1'b0}});
   assign stall_o    = stall_s;
   assign regwrite_o = stall_s ? 1'b0 : regwrite_i;
   assign regdst_o   = regdst_i;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its aluop/alusrc/regsrc/regdst/regwrite outputs and feeds the EX/MEM register.
- Resolves operand forwarding from EX/MEM and MEM/WB, computes single-cycle ALU results combinationally.
- Runs a 16-iteration shift-add multiplier and restoring unsigned divider under an FSM, raising stall_o to the hazard unit for the whole operation.

Parameters:
WIDTH, 16, datapath width; the iteration count equals WIDTH
NOREG, 4'hF, regsrc code meaning "operand is not a register" (no forwarding)

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  asynchronous, active-high reset
aluop_i  input  4  operation from ID/EX
alusrc1_i / alusrc2_i  input  16  operand values from ID/EX
regsrc1_i / regsrc2_i  input  4  source register indices of the operands
regwrite_i  input  1  writeback enable from ID/EX
regdst_i  input  4  destination register from ID/EX
exmem_regwrite_i, exmem_regdst_i[3:0], exmem_result_i[15:0]  input  EX/MEM forwarding source
memwb_regwrite_i, memwb_regdst_i[3:0], memwb_result_i[15:0]  input  MEM/WB forwarding source
result_o  output  16  ALU result to EX/MEM
zero_o  output  1  result_o == 0
regwrite_o  output  1  regwrite_i gated: 0 while stall_o=1
regdst_o  output  4  regdst_i passthrough
stall_o  output  1  freeze IF/ID and ID/EX, bubble EX/MEM

Behaviour:
- Forwarding, per operand n: if regsrcn_i != NOREG, exmem_regwrite_i=1 and exmem_regdst_i==regsrcn_i, use exmem_result_i. Else the same test against MEM/WB, using memwb_result_i. Else use alusrcn_i. EX/MEM has priority.
- aluop encoding (A, B = forwarded operands; all ops mod 2^16):
  - 0 ADD, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SLL A<<B[3:0], 7 SRL, 8 SRA A>>>B[3:0]
  - 9 SLT signed (1/0), A SLTU (1/0), B pass B, F pass A
  - C MUL low 16 bits, D DIVU quotient, E MFHI (see optional feature)
- FSM states:
  - IDLE: aluop C/D present means the op is started. Forwarded A/B are latched into internal operand registers at that posedge, counter=0. stall_o=1 combinationally in the issue cycle. Next state RUN.
  - RUN: one iteration per cycle using the latched operands only; forwarding inputs are ignored, since the sources drain during the stall. stall_o=1. After the 16th iteration (counter==15), next state DONE.
  - DONE: stall_o=0, result_o=latched MUL/DIV result, regwrite_o=regwrite_i. ID/EX advances at this edge. Next state IDLE unconditionally, so the same instruction never restarts.
- Latency: issue cycle + 16 RUN cycles + DONE. stall_o is high for exactly 17 cycles and the result is visible in cycle 18.
- MUL: full 32-bit product; result_o = low 16 bits.
- DIVU: unsigned restoring division. Divide by zero gives quotient 16'hFFFF and remainder = dividend; it still takes 17 stall cycles.
- Non-C/D ops in IDLE: result is combinational from forwarded operands, stall_o=0, zero-cycle latency.
- RST asserted, including mid-RUN: FSM goes to IDLE, counter=0, operand/product/HI registers=0. stall_o forced 0 while RST=1. After release, a C/D op present on aluop_i starts fresh.
- regdst_o always equals regdst_i. regwrite_o=0 whenever stall_o=1.

Optional Feature:
EX_HILO_EN
- Defined:
  - A 16-bit HI register, reset 0, is written in DONE with the MUL high 16 bits or the DIVU remainder.
  - aluop E returns HI, with no stall.
  - If op E directly follows a C/D op, it sees the updated HI.
- Undefined: the high/remainder bits are discarded, no HI register exists, and aluop E returns 16'h0000.

Test Plan:
- Reset check: RST pulse -> stall_o=0, result_o=0 with aluop=0 and both operands 0, zero_o=1.
- ADD with forwarding: regsrc1=3, alusrc1=5, exmem (regwrite=1, regdst=3, result=16'h0010), memwb (regdst=3, result=16'h0020), alusrc2=1 -> result_o=16'h0011. Same test with exmem_regwrite=0 -> 16'h0021.
- MUL: A=16'h1234, B=16'h0100 -> stall_o high for exactly 17 cycles, then result_o=16'h3400 for one cycle. With EX_HILO_EN, a following op E returns 16'h0012.
- DIVU: A=16'd100, B=16'd7 -> quotient 16'd14, HI=2 with EX_HILO_EN. B=0 -> quotient 16'hFFFF, HI=100.
- Operand hold: change the forwarding inputs and alusrc each cycle during RUN -> MUL result still matches the operands latched at issue.
- Reset mid-operation: assert RST at RUN cycle 8 -> stall_o drops immediately. After release with the same MUL on aluop_i, a full 17-cycle stall occurs and the result is correct.
